// File: rtl/mole_hit_scorer.sv
// mole_hit_scorer: classifies switch toggles as hits or misses against the lit moles, keeps a saturating
// score, flags whacked moles and derives the difficulty level from the score.
module mole_hit_scorer #(
  parameter int NUM_MOLES    = 18,
  parameter int SCORE_WIDTH  = 10,
  parameter int MAX_SCORE    = 999,
  parameter int MISS_PENALTY = 1,
  parameter int LVL1_SCORE   = 25,
  parameter int LVL2_SCORE   = 50,
  parameter int LVL3_SCORE   = 75
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic [NUM_MOLES-1:0]   ledr_i,
  input  logic [NUM_MOLES-1:0]   sw_i,
  output logic [SCORE_WIDTH-1:0] score_o,
  output logic [1:0]             level_o,
  output logic [NUM_MOLES-1:0]   whacked_o,
  output logic                   hit_pulse_o,
  output logic                   miss_pulse_o
);
  typedef enum logic [1:0] {IDLE, UP, WHACKED} mole_e;
  localparam int CW = $clog2(NUM_MOLES + 1);
  localparam int W = SCORE_WIDTH + 8;
  localparam logic signed [W-1:0] PEN = W'(MISS_PENALTY);
  localparam logic signed [W-1:0] MAX_W = W'(MAX_SCORE);
  localparam logic [SCORE_WIDTH-1:0] MAX_V = SCORE_WIDTH'(MAX_SCORE);
  localparam logic [SCORE_WIDTH-1:0] L1 = SCORE_WIDTH'(LVL1_SCORE);
  localparam logic [SCORE_WIDTH-1:0] L2 = SCORE_WIDTH'(LVL2_SCORE);
  localparam logic [SCORE_WIDTH-1:0] L3 = SCORE_WIDTH'(LVL3_SCORE);
  logic [NUM_MOLES-1:0] s1_q, s2_q, s3_q, whack, hit, miss;
  logic [1:0] warm_q;
  mole_e st_q [NUM_MOLES];
  mole_e st_d [NUM_MOLES];
  logic [CW-1:0] nh, nm;
  logic signed [W-1:0] sc_x, nh_x, nm_x, nxt;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic [1:0] level_q, level_d;
  logic hit_q, miss_q;
  assign whack = (warm_q == 2'd0) ? (s2_q ^ s3_q) : '0;
  always_comb begin
    hit = '0;
    miss = '0;
    nh = '0;
    nm = '0;
    for (int i = 0; i < NUM_MOLES; i++) begin
      hit[i] = enable_i && whack[i] && (st_q[i] == UP);
      miss[i] = enable_i && whack[i] && (st_q[i] != UP);
      st_d[i] = !enable_i ? IDLE : hit[i] ? WHACKED : !ledr_i[i] ? IDLE : (st_q[i] == IDLE) ? UP : st_q[i];
      nh = nh + CW'(hit[i]);
      nm = nm + CW'(miss[i]);
    end
    sc_x = W'(score_q);
    nh_x = W'(nh);
    nm_x = W'(nm);
    nxt = sc_x + nh_x - nm_x * PEN;
    score_d = (nxt < 0) ? '0 : (nxt > MAX_W) ? MAX_V : nxt[SCORE_WIDTH-1:0];
    level_d = (score_q >= L3) ? 2'd3 : (score_q >= L2) ? 2'd2 : (score_q >= L1) ? 2'd1 : 2'd0;
  end
  always_comb begin
    whacked_o = '0;
    for (int i = 0; i < NUM_MOLES; i++) whacked_o[i] = (st_q[i] == WHACKED);
  end
  // During warmup s3 copies s1 so it has caught up with s2 by the time the mask lifts.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      warm_q <= 2'd2;
      score_q <= '0;
      level_q <= '0;
      hit_q <= 1'b0;
      miss_q <= 1'b0;
      for (int i = 0; i < NUM_MOLES; i++) st_q[i] <= IDLE;
    end else begin
      s1_q <= sw_i;
      s2_q <= s1_q;
      s3_q <= (warm_q != 2'd0) ? s1_q : s2_q;
      warm_q <= warm_q - 2'(warm_q != 2'd0);
      score_q <= score_d;
      level_q <= level_d;
      hit_q <= (nh != '0);
      miss_q <= (nm != '0);
      for (int i = 0; i < NUM_MOLES; i++) st_q[i] <= st_d[i];
    end
  end
  assign score_o = score_q;
  assign level_o = level_q;
  assign hit_pulse_o = hit_q;
  assign miss_pulse_o = miss_q;
endmodule

// File: tb/tb_mole_hit_scorer.sv
// tb_mole_hit_scorer: directed scenarios with spec constants plus a randomized run against a
// behavioural model of hits, misses and score saturation.
module tb_mole_hit_scorer;
  logic clk = 1'b0;
  logic reset, enable;
  logic [17:0] ledr, sw;
  logic [9:0] score;
  logic [1:0] level;
  logic [17:0] whacked;
  logic hit_pulse, miss_pulse;
  int passed = 0;
  int total = 0;
  mole_hit_scorer dut (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .ledr_i(ledr), .sw_i(sw),
    .score_o(score), .level_o(level), .whacked_o(whacked),
    .hit_pulse_o(hit_pulse), .miss_pulse_o(miss_pulse)
  );
  always #5 clk = ~clk;
  // Model: moles are 0 = not tracked, 1 = up and unhit, 2 = already hit.
  int m_edges, m_score, m_level;
  int mst [18];
  logic [17:0] d1, d2, d3, m_whacked;
  bit m_hit, m_miss;
  function automatic int lvl(input int s);
    return s >= 75 ? 3 : s >= 50 ? 2 : s >= 25 ? 1 : 0;
  endfunction
  task automatic model_step();
    logic [17:0] w;
    int nh, nm;
    if (reset) begin
      m_edges = 0; d1 = '0; d2 = '0; d3 = '0;
      m_score = 0; m_level = 0; m_hit = 0; m_miss = 0;
      foreach (mst[i]) mst[i] = 0;
    end else begin
      w = (m_edges >= 3) ? (d2 ^ d3) : '0;
      m_edges++;
      d3 = d2; d2 = d1; d1 = sw;
      m_level = lvl(m_score);
      nh = 0; nm = 0;
      foreach (mst[i]) begin
        if (!enable) mst[i] = 0;
        else if (w[i] && mst[i] == 1) begin nh++; mst[i] = 2; end
        else begin
          if (w[i]) nm++;
          if (!ledr[i]) mst[i] = 0;
          else if (mst[i] == 0) mst[i] = 1;
        end
      end
      m_score = m_score + nh - nm;
      if (m_score < 0) m_score = 0;
      if (m_score > 999) m_score = 999;
      m_hit = nh != 0;
      m_miss = nm != 0;
    end
    foreach (mst[i]) m_whacked[i] = (mst[i] == 2);
  endtask
  always @(posedge clk) model_step();
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask
  task automatic hit_round(input logic [17:0] mask);
    ledr = '1;
    step(1);
    sw ^= mask;
    step(3);
    ledr = '0;
    step(1);
  endtask
  task automatic test_reset();
    sw = '1; ledr = '0; enable = 1'b1;
    do_reset();
    total++; if (score !== 10'd0 || level !== 2'd0 || whacked !== 18'd0) $display("FAIL reset_state score=%0d level=%0d whacked=%h exp 0/0/0", score, level, whacked); else passed++;
    total++; if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0) $display("FAIL reset_pulses hit=%b miss=%b exp 0/0", hit_pulse, miss_pulse); else passed++;
    for (int c = 0; c < 10; c++) begin
      step(1);
      total++; if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0) $display("FAIL warmup_pulse cyc=%0d hit=%b miss=%b exp 0/0", c, hit_pulse, miss_pulse); else passed++;
      total++; if (score !== 10'd0 || level !== 2'd0) $display("FAIL warmup_score cyc=%0d score=%0d level=%0d exp 0/0", c, score, level); else passed++;
    end
  endtask
  task automatic test_hit_miss();
    ledr[3] = 1'b1;
    step(1);
    sw[3] = ~sw[3];
    step(2);
    total++; if (hit_pulse !== 1'b0) $display("FAIL hit_early got %b exp 0", hit_pulse); else passed++;
    step(1);
    total++; if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0) $display("FAIL hit_pulse hit=%b miss=%b exp 1/0", hit_pulse, miss_pulse); else passed++;
    total++; if (score !== 10'd1 || whacked[3] !== 1'b1) $display("FAIL hit_score score=%0d whacked3=%b exp 1/1", score, whacked[3]); else passed++;
    step(1);
    total++; if (hit_pulse !== 1'b0) $display("FAIL hit_one_cycle got %b exp 0", hit_pulse); else passed++;
    sw[3] = ~sw[3];
    step(3);
    total++; if (miss_pulse !== 1'b1 || score !== 10'd0 || whacked[3] !== 1'b1) $display("FAIL rewhack_miss miss=%b score=%0d whacked3=%b exp 1/0/1", miss_pulse, score, whacked[3]); else passed++;
    ledr[3] = 1'b0;
    step(1);
    total++; if (whacked[3] !== 1'b0) $display("FAIL whacked_clear got %b exp 0", whacked[3]); else passed++;
  endtask
  task automatic test_floor();
    sw[5] = ~sw[5];
    step(3);
    total++; if (miss_pulse !== 1'b1 || hit_pulse !== 1'b0 || score !== 10'd0) $display("FAIL floor miss=%b hit=%b score=%0d exp 1/0/0", miss_pulse, hit_pulse, score); else passed++;
  endtask
  task automatic test_multi();
    ledr = 18'b11;
    step(1);
    sw ^= 18'b111;
    step(3);
    total++; if (hit_pulse !== 1'b1 || miss_pulse !== 1'b1) $display("FAIL multi_pulses hit=%b miss=%b exp 1/1", hit_pulse, miss_pulse); else passed++;
    total++; if (score !== 10'd1 || whacked[2:0] !== 3'b011) $display("FAIL multi_score score=%0d whacked=%b exp 1/011", score, whacked[2:0]); else passed++;
    ledr = '0;
    step(1);
  endtask
  task automatic test_level();
    do_reset();
    step(4);
    hit_round('1);
    hit_round(18'h3F);
    total++; if (score !== 10'd24 || level !== 2'd0) $display("FAIL level_24 score=%0d level=%0d exp 24/0", score, level); else passed++;
    ledr = '1;
    step(1);
    sw[0] = ~sw[0];
    step(3);
    total++; if (score !== 10'd25 || level !== 2'd0) $display("FAIL level_25_lag score=%0d level=%0d exp 25/0", score, level); else passed++;
    step(1);
    total++; if (level !== 2'd1) $display("FAIL level_25 got %0d exp 1", level); else passed++;
    ledr = '0;
    step(1);
    for (int r = 0; r < 55; r++) hit_round('1);
    total++; if (score !== 10'd999 || level !== 2'd3) $display("FAIL ceiling score=%0d level=%0d exp 999/3", score, level); else passed++;
    ledr = '1;
    step(1);
    sw[9] = ~sw[9];
    step(3);
    total++; if (hit_pulse !== 1'b1 || score !== 10'd999) $display("FAIL ceiling_hold hit=%b score=%0d exp 1/999", hit_pulse, score); else passed++;
    ledr = '0;
    step(1);
  endtask
  task automatic test_enable();
    do_reset();
    step(4);
    ledr = '1;
    step(1);
    sw ^= 18'h3FF;
    step(3);
    total++; if (score !== 10'd10 || whacked[4] !== 1'b1) $display("FAIL en_setup score=%0d whacked4=%b exp 10/1", score, whacked[4]); else passed++;
    enable = 1'b0;
    sw[7] = ~sw[7];
    for (int c = 0; c < 3; c++) begin
      step(1);
      total++; if (score !== 10'd10 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0 || whacked !== 18'd0) $display("FAIL disabled cyc=%0d score=%0d hit=%b miss=%b whacked=%h exp 10/0/0/0", c, score, hit_pulse, miss_pulse, whacked); else passed++;
    end
    enable = 1'b1;
    step(1);
    sw[7] = ~sw[7];
    step(3);
    total++; if (hit_pulse !== 1'b1 || score !== 10'd11) $display("FAIL reenable_hit hit=%b score=%0d exp 1/11", hit_pulse, score); else passed++;
  endtask
  task automatic test_back_to_back();
    sw[12] = ~sw[12];
    step(1);
    sw[13] = ~sw[13];
    step(2);
    total++; if (hit_pulse !== 1'b1 || score !== 10'd12) $display("FAIL b2b_first hit=%b score=%0d exp 1/12", hit_pulse, score); else passed++;
    step(1);
    total++; if (hit_pulse !== 1'b1 || score !== 10'd13) $display("FAIL b2b_second hit=%b score=%0d exp 1/13", hit_pulse, score); else passed++;
    ledr = '0;
    step(1);
  endtask
  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(199) == 0);
      enable = ($urandom_range(9) != 0);
      for (int i = 0; i < 18; i++) begin
        if ($urandom_range(5) == 0) ledr[i] = ~ledr[i];
        if ($urandom_range(7) == 0) sw[i] = ~sw[i];
      end
      step(1);
      total++; if (score !== 10'(m_score) || level !== 2'(m_level)) $display("FAIL rand_score cyc=%0d score=%0d level=%0d exp %0d/%0d", c, score, level, m_score, m_level); else passed++;
      total++; if (hit_pulse !== m_hit || miss_pulse !== m_miss || whacked !== m_whacked) $display("FAIL rand_flags cyc=%0d hit=%b miss=%b whacked=%h exp %b/%b/%h", c, hit_pulse, miss_pulse, whacked, m_hit, m_miss, m_whacked); else passed++;
    end
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1; enable = 1'b1; ledr = '0; sw = '0;
    step(1);
    test_reset();
    test_hit_miss();
    test_floor();
    test_multi();
    test_level();
    test_enable();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
